// File: rtl/buffer_ctrl.sv
// Address/occupancy controller for a circular word buffer: K-word load beats in,
// J-word read beats out, with a run/drain/clear sequencing FSM.
module buffer_ctrl #(
  parameter int SIZE = 16,
  parameter int K    = 4,
  parameter int J    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     drain,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ld,
  output logic [$clog2(SIZE)-1:0]  write_add,
  output logic [$clog2(SIZE)-1:0]  read_add,
  output logic [$clog2(SIZE):0]    count,
  output logic                     full,
  output logic                     empty,
  output logic                     drain_done
);

  localparam int BIT = $clog2(SIZE);

  // Occupancy arithmetic is done two bits wider than the pointers so SIZE,
  // K and J are all representable and subtraction cannot alias.
  localparam logic [BIT+1:0] SIZE_W = (BIT+2)'(SIZE);
  localparam logic [BIT+1:0] K_W    = (BIT+2)'(K);
  localparam logic [BIT+1:0] J_W    = (BIT+2)'(J);
  localparam logic [BIT-1:0] K_STEP = BIT'(K % SIZE);
  localparam logic [BIT-1:0] J_STEP = BIT'(J % SIZE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    CLEAR
  } state_t;

  state_t         state;
  logic           wr;
  logic           rd;
  logic [BIT+1:0] count_w;
  logic [BIT+1:0] count_next;

  assign count_w    = {1'b0, count};

  assign in_ready   = (state == RUN) && ((SIZE_W - count_w) >= K_W);
  assign out_valid  = ((state == RUN) || (state == DRAIN)) && (count_w >= J_W);

  assign wr         = in_valid && in_ready;
  assign rd         = out_valid && out_ready;
  assign ld         = wr;

  assign full       = count_w > (SIZE_W - K_W);
  assign empty      = (count == '0);
  assign drain_done = (state == CLEAR);

  always_comb begin
    count_next = count_w;
    if (wr) count_next = count_next + K_W;
    if (rd) count_next = count_next - J_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      write_add <= '0;
      read_add  <= '0;
      count     <= '0;
    end else begin
      if (wr) write_add <= write_add + K_STEP;
      if (rd) read_add  <= read_add + J_STEP;
      count <= count_next[BIT:0];

      case (state)
        IDLE: begin
          if (drain)   state <= DRAIN;
          else if (en) state <= RUN;
        end
        RUN: begin
          if (drain)    state <= DRAIN;
          else if (!en) state <= IDLE;
        end
        DRAIN: begin
          // Pointers are zeroed on entry to CLEAR so the pulse cycle already
          // shows the emptied buffer; the leftover (< J) words are dropped.
          if (count_next < J_W) begin
            state     <= CLEAR;
            write_add <= '0;
            read_add  <= '0;
            count     <= '0;
          end
        end
        CLEAR: begin
          state     <= IDLE;
          write_add <= '0;
          read_add  <= '0;
          count     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed self-checking bench for buffer_ctrl at SIZE=16, K=4, J=8.
module tb_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, drain, in_valid, out_ready;
  logic       in_ready, out_valid, ld, full, empty, drain_done;
  logic [3:0] write_add, read_add;
  logic [4:0] count;

  int n_vec = 0;
  int n_err = 0;

  buffer_ctrl #(.SIZE(16), .K(4), .J(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .drain     (drain),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ld        (ld),
    .write_add (write_add),
    .read_add  (read_add),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; drain = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    tick;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ld", int'(ld), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_drain_done", int'(drain_done), 0);
    check("rst_count", int'(count), 0);

    // IDLE -> RUN
    rst = 1'b0; en = 1'b1;
    tick;
    check("run_in_ready", int'(in_ready), 1);
    check("run_empty", int'(empty), 1);
    check("run_count", int'(count), 0);
    check("run_write_add", int'(write_add), 0);
    check("run_read_add", int'(read_add), 0);

    // Four load beats fill the buffer
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("fill_ld", int'(ld), 1);
      tick;
      check("fill_count", int'(count), 4 * i);
      check("fill_write_add", int'(write_add), (4 * i) % 16);
    end
    check("full_flag", int'(full), 1);
    check("full_in_ready", int'(in_ready), 0);
    check("full_out_valid", int'(out_valid), 1);
    #1;
    check("full_ld_blocked", int'(ld), 0);
    tick;
    check("full_count_hold", int'(count), 16);

    // One read beat: 16 -> 8
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    check("rd1_count", int'(count), 8);
    check("rd1_read_add", int'(read_add), 8);

    // Concurrent write and read at count 8
    in_valid = 1'b1;
    #1;
    check("both_ld", int'(ld), 1);
    tick;
    check("both_count", int'(count), 4);
    check("both_write_add", int'(write_add), 4);
    check("both_read_add", int'(read_add), 0);

    // Write once more to reach 8 with read_add 0, then read it out
    out_ready = 1'b0;
    tick;
    check("w8_count", int'(count), 8);
    check("w8_write_add", int'(write_add), 8);
    check("w8_out_valid", int'(out_valid), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    check("rd2_read_add", int'(read_add), 8);
    check("rd2_count", int'(count), 0);
    check("rd2_out_valid", int'(out_valid), 0);
    check("rd2_empty", int'(empty), 1);

    // Fill to 12 then drain
    out_ready = 1'b0; in_valid = 1'b1;
    tick; tick; tick;
    check("pre_drain_count", int'(count), 12);
    check("pre_drain_write_add", int'(write_add), 4);
    in_valid = 1'b0; drain = 1'b1;
    tick;
    check("drain_in_ready", int'(in_ready), 0);
    check("drain_out_valid", int'(out_valid), 1);
    check("drain_done_early", int'(drain_done), 0);
    check("drain_count", int'(count), 12);
    drain = 1'b0; out_ready = 1'b1;
    tick;
    check("clear_drain_done", int'(drain_done), 1);
    check("clear_count", int'(count), 0);
    check("clear_write_add", int'(write_add), 0);
    check("clear_read_add", int'(read_add), 0);
    check("clear_out_valid", int'(out_valid), 0);
    out_ready = 1'b0;
    tick;
    check("post_clear_drain_done", int'(drain_done), 0);
    check("post_clear_idle", int'(in_ready), 0);
    tick;
    check("rerun_in_ready", int'(in_ready), 1);

    // Reset during DRAIN with count 12
    in_valid = 1'b1;
    tick; tick; tick;
    check("pre_rst_count", int'(count), 12);
    in_valid = 1'b0; drain = 1'b1;
    tick;
    check("drain2_drain_done", int'(drain_done), 0);
    rst = 1'b1; out_ready = 1'b1;
    tick;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_write_add", int'(write_add), 0);
    check("mid_rst_read_add", int'(read_add), 0);
    check("mid_rst_drain_done", int'(drain_done), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_empty", int'(empty), 1);
    rst = 1'b0; drain = 1'b0; out_ready = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_drain_done", int'(drain_done), 0);
      check("post_rst_in_ready", int'(in_ready), 0);
    end

    // drain beats en in IDLE; empty DRAIN goes straight to CLEAR
    en = 1'b1; drain = 1'b1;
    tick;
    check("prio_in_ready", int'(in_ready), 0);
    check("prio_drain_done", int'(drain_done), 0);
    en = 1'b0; drain = 1'b0;
    tick;
    check("prio_clear_pulse", int'(drain_done), 1);
    tick;
    check("prio_pulse_end", int'(drain_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
